sm4_round_sequencer: RTL
========================

# sm4_round_sequencer

Sequencer for the SM4 core: accepts one 128-bit block plus key and direction, runs key expansion and the 32 cipher rounds one per cycle, and returns the result. It owns the round-key store, the X0..X3 working registers and the state machine. It time-shares a single external combinational T-function unit (`sm4_t_func`: S-box plus L or L′) between key expansion and encryption. Sits between the bus-side request interface and `sm4_t_func`.

## Interface
- No parameters; all widths and constants come from `sm4_encryptor_pkg`.
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `v_i` in 1: request valid.
- `ready_o` out 1: request accepted when `v_i & ready_o`.
- `key_i` in 128: cipher key, MK0 in [127:96].
- `data_i` in 128: input block, X0 in [127:96].
- `decrypt_i` in 1: 1 = decrypt, 0 = encrypt.
- `v_o` out 1: result valid.
- `ready_i` in 1: consumer accepts when `v_o & ready_i`.
- `data_o` out 128: result block.
- `t_data_o` out 32: T-function input.
- `t_key_mode_o` out 1: 1 = key-expansion T′ (L′), 0 = cipher T (L).
- `t_data_i` in 32: T-function output, combinational from `t_data_o`/`t_key_mode_o`.

## Operation
- States (`state_e`): eIdle, eCheckKey, eEvaKey, eLoadCrypt, eCrypt, eReverse, eDone.
- **eIdle:** `ready_o` = 1.
  - On accept, latch `key_i`, `data_i` and `decrypt_i`, then go to eCheckKey.
- **eCheckKey (1 cycle):** go to eEvaKey, or to eLoadCrypt on a cache hit (see Configuration).
- **eEvaKey (32 cycles, round counter i = 0..31):**
  - Initialise K = key ^ `key_xor_mask_p`.
  - Each cycle:
    - `t_data_o` = K1^K2^K3^`key_aux_p[i]`, with `t_key_mode_o` = 1.
    - rk[i] = K0 ^ `t_data_i`.
    - Shift K left one word, inserting rk[i].
  - After i = 31, go to eLoadCrypt.
- **eLoadCrypt (1 cycle):** X0..X3 ← latched data; reset the round counter.
- **eCrypt (32 cycles, i = 0..31):**
  - Round key: j = i when encrypting, j = 31−i when decrypting.
  - `t_data_o` = X1^X2^X3^rk[j], with `t_key_mode_o` = 0.
  - New word = X0 ^ `t_data_i`; shift X left one word.
- **eReverse (1 cycle):** `data_o` ← {X3, X2, X1, X0} (the R reversal).
- **eDone:**
  - `v_o` = 1; `data_o` is held stable.
  - On `ready_i`, go to eIdle.
- `t_key_mode_o` = 0 and `t_data_o` = 0 outside eEvaKey and eCrypt.
- All word XORs are 32-bit with no carries. The round counter is 5 bits and wraps from 31 to 0 on the state exit.

## Timing
- Reset values:
  - state = eIdle, `ready_o` = 1, `v_o` = 0, `data_o` = 0, `t_data_o` = 0, `t_key_mode_o` = 0.
  - Round counter = 0; key-cache valid = 0.
  - rk array contents are don't-care.
- Latency from the accepting edge to `v_o` rising:
  - 67 cycles with key expansion (1 + 32 + 1 + 32 + 1).
  - 35 cycles on a cache hit.
- One request in flight. `ready_o` = 0 in every state except eIdle. There is no accept in the same cycle that eDone drains; the next accept is possible one cycle after the `v_o & ready_i` handshake.
- `v_o` stays asserted, and `data_o` stays stable, until `ready_i`. Unbounded backpressure is allowed.
- Reset mid-operation (any state) returns to eIdle next edge and clears cache-valid, so a partially expanded key is never reused.
- `v_i` is ignored in every state except eIdle. `key_i`, `data_i` and `decrypt_i` are sampled only on accept.

## Configuration
- `SM4_KEY_CACHE_EN` defined:
  - A 128-bit last-key register and a valid bit are kept. Valid is set when eEvaKey completes.
  - In eCheckKey, a request whose key equals the stored key while valid = 1 skips to eLoadCrypt and reuses rk.
  - Encryption and decryption share the same rk.
- `SM4_KEY_CACHE_EN` not defined:
  - eCheckKey always goes to eEvaKey.
  - No last-key register is present; latency is always 67.

## Structure
- `sm4_encryptor_pkg` holds all shared types and constants: `state_e`, `key_xor_mask_p`, `key_aux_p` (CK[i] = `key_aux_p[i]`), the width parameters and `turn_key_num_p`. No new typedefs are added outside the package.
- One sub-module: `sm4_rk_file`, a 32×32 round-key register file.
  - One write port, indexed by i in eEvaKey.
  - One combinational read port, indexed by j in eCrypt.
- `sm4_t_func` stays outside the sequencer; the bench instantiates the real one.

## Test plan
- **Standard vector:** key = data = 0123456789abcdeffedcba9876543210, encrypt → `data_o` = 681edf34d206965e86b3e94f536e4246, with `v_o` rising 67 cycles after accept.
- **Decrypt:** same key, data = 681edf34d206965e86b3e94f536e4246, decrypt → 0123456789abcdeffedcba9876543210.
  - 35-cycle latency with `SM4_KEY_CACHE_EN`; 67 without.
- **Key change:** a back-to-back request with key = 00…01 → full 67-cycle expansion; the result matches the golden model.
- **Backpressure:** hold `ready_i` = 0 for 20 cycles in eDone → `v_o` and `data_o` are stable and `ready_o` = 0; accept happens only after the handshake.
- **Reset mid-operation:** assert `reset_i` during cycle 10 of eEvaKey → all outputs return to their reset values.
  - A following request with the same key takes 67 cycles (cache invalidated).
- **Ignored input:** `v_i` held at 1 with changing data during eCrypt → no accept and no effect on the result.

Source files
------------

// File: rtl/sm4_encryptor_pkg.sv
// Shared types and constants for the SM4 encryptor: FSM states, request
// payload, FK/CK constants and the S-box.
package sm4_encryptor_pkg;

  localparam int unsigned word_width_p      = 32;
  localparam int unsigned block_width_p     = 128;
  localparam int unsigned turn_key_num_p    = 32;
  localparam int unsigned round_cnt_width_p = 5;

  typedef enum logic [2:0] {
    eIdle,
    eCheckKey,
    eEvaKey,
    eLoadCrypt,
    eCrypt,
    eReverse,
    eDone
  } state_e;

  typedef struct packed {
    logic [block_width_p-1:0] key;
    logic [block_width_p-1:0] data;
    logic                     decrypt;
  } sm4_req_s;

  // FK system parameter
  localparam logic [block_width_p-1:0] key_xor_mask_p =
    128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  // CK[i]: byte j of word i is (4i+j)*7 mod 256
  localparam logic [0:turn_key_num_p-1][word_width_p-1:0] key_aux_p = {
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [0:255][7:0] sbox_p = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Byte-wise S-box substitution of one word (tau)
  function automatic logic [word_width_p-1:0] sbox_word(input logic [word_width_p-1:0] a);
    return {sbox_p[a[31:24]], sbox_p[a[23:16]], sbox_p[a[15:8]], sbox_p[a[7:0]]};
  endfunction

endpackage

// File: rtl/sm4_rk_file.sv
// 32x32 round-key register file: one write port (key expansion) and one
// combinational read port (cipher rounds).
module sm4_rk_file
  import sm4_encryptor_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [round_cnt_width_p-1:0] waddr_i,
  input  logic [word_width_p-1:0]      wdata_i,
  input  logic [round_cnt_width_p-1:0] raddr_i,
  output logic [word_width_p-1:0]      rdata_o
);

  logic [word_width_p-1:0] mem_q [turn_key_num_p];

  // Contents are don't-care after reset, so no reset on the array
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sm4_t_func.sv
// SM4 T-function: S-box followed by L (cipher) or L' (key expansion).
module sm4_t_func
  import sm4_encryptor_pkg::*;
(
  input  logic [word_width_p-1:0] data_i,
  input  logic                    key_mode_i,
  output logic [word_width_p-1:0] data_o
);

  logic [word_width_p-1:0] b;

  assign b = sbox_word(data_i);

  always_comb begin
    data_o = '0;
    if (key_mode_i) begin
      data_o = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    end else begin
      data_o = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    end
  end

endmodule

// File: rtl/sm4_round_sequencer.sv
// SM4 round sequencer: key expansion then 32 cipher rounds sharing one
// external T-function. Define SM4_KEY_CACHE_EN to reuse round keys for a repeated key.
module sm4_round_sequencer
  import sm4_encryptor_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [block_width_p-1:0] key_i,
  input  logic [block_width_p-1:0] data_i,
  input  logic                     decrypt_i,
  output logic                     v_o,
  input  logic                     ready_i,
  output logic [block_width_p-1:0] data_o,
  output logic [word_width_p-1:0]  t_data_o,
  output logic                     t_key_mode_o,
  input  logic [word_width_p-1:0]  t_data_i
);

  localparam logic [round_cnt_width_p-1:0] last_round_lp = round_cnt_width_p'(turn_key_num_p - 1);

  state_e                       state_q, state_d;
  logic [round_cnt_width_p-1:0] cnt_q, cnt_d;
  logic [block_width_p-1:0]     work_q, work_d;
  sm4_req_s                     req_q, req_d;
  logic [block_width_p-1:0]     data_q, data_d;
  logic                         v_q, v_d;
  logic                         ready_q, ready_d;

  logic                         rk_we;
  logic [word_width_p-1:0]      rk_wdata;
  logic [round_cnt_width_p-1:0] rk_raddr;
  logic [word_width_p-1:0]      rk_rdata;
  logic                         key_hit;

  // Working words: W0 is [127:96], W3 is [31:0]
  logic [word_width_p-1:0] w0, w1, w2, w3;
  assign w0 = work_q[127:96];
  assign w1 = work_q[95:64];
  assign w2 = work_q[63:32];
  assign w3 = work_q[31:0];

  sm4_rk_file u_rk_file (
    .clk_i   (clk_i),
    .we_i    (rk_we),
    .waddr_i (cnt_q),
    .wdata_i (rk_wdata),
    .raddr_i (rk_raddr),
    .rdata_o (rk_rdata)
  );

`ifdef SM4_KEY_CACHE_EN
  logic [block_width_p-1:0] last_key_q;
  logic                     cache_vld_q;

  assign key_hit = cache_vld_q && (last_key_q == req_q.key);

  // Valid drops as soon as an expansion starts so a partial key is never reused
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cache_vld_q <= 1'b0;
      last_key_q  <= '0;
    end else if (state_q == eEvaKey && cnt_q == last_round_lp) begin
      cache_vld_q <= 1'b1;
      last_key_q  <= req_q.key;
    end else if (state_q == eCheckKey && !key_hit) begin
      cache_vld_q <= 1'b0;
    end
  end
`else
  assign key_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      v_q     <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      v_q     <= v_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    work_q <= work_d;
    req_q  <= req_d;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    req_d        = req_q;
    data_d       = data_q;
    t_data_o     = '0;
    t_key_mode_o = 1'b0;
    rk_we        = 1'b0;
    rk_wdata     = w0 ^ t_data_i;
    rk_raddr     = cnt_q;

    unique case (state_q)
      eIdle: begin
        if (v_i && ready_q) begin
          req_d   = '{key: key_i, data: data_i, decrypt: decrypt_i};
          state_d = eCheckKey;
        end
      end
      eCheckKey: begin
        work_d  = req_q.key ^ key_xor_mask_p;
        cnt_d   = '0;
        state_d = key_hit ? eLoadCrypt : eEvaKey;
      end
      eEvaKey: begin
        t_key_mode_o = 1'b1;
        t_data_o     = w1 ^ w2 ^ w3 ^ key_aux_p[cnt_q];
        rk_we        = 1'b1;
        work_d       = {work_q[95:0], rk_wdata};
        cnt_d        = cnt_q + round_cnt_width_p'(1);
        if (cnt_q == last_round_lp) begin
          state_d = eLoadCrypt;
        end
      end
      eLoadCrypt: begin
        work_d  = req_q.data;
        cnt_d   = '0;
        state_d = eCrypt;
      end
      eCrypt: begin
        // 31-i on a 5-bit counter is its bitwise complement
        rk_raddr = req_q.decrypt ? ~cnt_q : cnt_q;
        t_data_o = w1 ^ w2 ^ w3 ^ rk_rdata;
        work_d   = {work_q[95:0], w0 ^ t_data_i};
        cnt_d    = cnt_q + round_cnt_width_p'(1);
        if (cnt_q == last_round_lp) begin
          state_d = eReverse;
        end
      end
      eReverse: begin
        data_d  = {w3, w2, w1, w0};
        state_d = eDone;
      end
      eDone: begin
        if (ready_i) begin
          state_d = eIdle;
        end
      end
      default: begin
        state_d = eIdle;
      end
    endcase

    v_d     = (state_d == eDone);
    ready_d = (state_d == eIdle);
  end

  assign ready_o = ready_q;
  assign v_o     = v_q;
  assign data_o  = data_q;

endmodule
